cmp_branch_ctrl: RTL

Compare-and-branch controller that sits directly downstream of the 4-bit magnitude comparator in the microcontroller datapath. It accepts compare requests from the decoder, drives the comparator's operand and enable inputs, and registers the three result flags into a status register. It then resolves conditional-branch requests against those flags and hands a taken/not-taken decision and target address to the program counter.

---
 rtl/cmp_branch_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cmp_branch_ctrl.sv
// rtl/cmp_branch_ctrl.sv - compare-and-branch controller behind the 4-bit magnitude comparator
// Optional feature macro: BRANCH_NEG_COND_EN (enables NE/LE/GE condition codes 4..6)
module cmp_branch_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmp_valid,
  input  logic [3:0]        i_cmp_a,
  input  logic [3:0]        i_cmp_b,
  output logic              o_cmp_ready,
  output logic [3:0]        o_operand1,
  output logic [3:0]        o_operand2,
  output logic              o_cmp_enable,
  input  logic              i_less,
  input  logic              i_equal,
  input  logic              i_greater,
  input  logic              i_br_valid,
  input  logic [2:0]        i_br_cond,
  input  logic [ADDR_W-1:0] i_br_target,
  output logic              o_br_ready,
  output logic              o_br_done,
  output logic              o_br_taken,
  output logic [ADDR_W-1:0] o_br_addr,
  output logic [2:0]        o_flags,
  output logic              o_flags_valid,
  output logic              o_flag_err
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CMP_DRIVE  = 2'd1,
    CMP_SAMPLE = 2'd2,
    BR_EVAL    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  // A request is accepted into a one-cycle launch slot before the FSM leaves IDLE,
  // so the operand/branch registers are stable before the comparator is enabled.
  logic                cmp_go_q, cmp_go_d;
  logic                br_go_q, br_go_d;
  logic                ready_q, ready_d;
  logic [3:0]          op1_q, op1_d;
  logic [3:0]          op2_q, op2_d;
  logic                enable_q, enable_d;
  logic [2:0]          cond_q, cond_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [2:0]          flags_q, flags_d;
  logic                fvalid_q, fvalid_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                taken_q, taken_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [2:0]          sample_flags;
  logic                sample_onehot;
  logic                cond_hit;

  assign sample_flags  = {i_greater, i_equal, i_less};
  assign sample_onehot = (sample_flags == 3'b001) || (sample_flags == 3'b010) ||
                         (sample_flags == 3'b100);

  // Resolve the latched condition code against the status register
  always_comb begin
    cond_hit = 1'b0;
    case (cond_q)
      3'd0: cond_hit = 1'b1;
      3'd1: cond_hit = fvalid_q & flags_q[0];
      3'd2: cond_hit = fvalid_q & flags_q[1];
      3'd3: cond_hit = fvalid_q & flags_q[2];
`ifdef BRANCH_NEG_COND_EN
      3'd4: cond_hit = fvalid_q & ~flags_q[1];
      3'd5: cond_hit = fvalid_q & (flags_q[0] | flags_q[1]);
      3'd6: cond_hit = fvalid_q & (flags_q[2] | flags_q[1]);
`else
      3'd4, 3'd5, 3'd6: cond_hit = 1'b0;
`endif
      default: cond_hit = 1'b0;
    endcase
  end

  // Next-state and next-output computation for the controller FSM
  always_comb begin
    state_d  = state_q;
    cmp_go_d = cmp_go_q;
    br_go_d  = br_go_q;
    ready_d  = ready_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    cond_d   = cond_q;
    target_d = target_q;
    flags_d  = flags_q;
    fvalid_d = fvalid_q;
    err_d    = err_q;
    enable_d = 1'b0;
    done_d   = 1'b0;
    taken_d  = 1'b0;
    addr_d   = '0;

    case (state_q)
      IDLE: begin
        if (cmp_go_q) begin
          cmp_go_d = 1'b0;
          enable_d = 1'b1;
          state_d  = CMP_DRIVE;
        end else if (br_go_q) begin
          br_go_d  = 1'b0;
          state_d  = BR_EVAL;
        end else if (ready_q && i_cmp_valid) begin
          // Compare has priority; a simultaneous branch waits and sees the new flags
          op1_d    = i_cmp_a;
          op2_d    = i_cmp_b;
          fvalid_d = 1'b0;
          cmp_go_d = 1'b1;
          ready_d  = 1'b0;
        end else if (ready_q && i_br_valid) begin
          cond_d   = i_br_cond;
          target_d = i_br_target;
          br_go_d  = 1'b1;
          ready_d  = 1'b0;
        end
      end
      CMP_DRIVE: begin
        enable_d = 1'b1;
        state_d  = CMP_SAMPLE;
      end
      CMP_SAMPLE: begin
        flags_d  = sample_flags;
        fvalid_d = 1'b1;
        if (!sample_onehot) begin
          err_d = 1'b1;
        end
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      BR_EVAL: begin
        done_d   = 1'b1;
        taken_d  = cond_hit;
        addr_d   = cond_hit ? target_q : '0;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cmp_go_q <= 1'b0;
      br_go_q  <= 1'b0;
      ready_q  <= 1'b1;
      op1_q    <= '0;
      op2_q    <= '0;
      enable_q <= 1'b0;
      cond_q   <= '0;
      target_q <= '0;
      flags_q  <= '0;
      fvalid_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmp_go_q <= cmp_go_d;
      br_go_q  <= br_go_d;
      ready_q  <= ready_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      enable_q <= enable_d;
      cond_q   <= cond_d;
      target_q <= target_d;
      flags_q  <= flags_d;
      fvalid_q <= fvalid_d;
      err_q    <= err_d;
      done_q   <= done_d;
      taken_q  <= taken_d;
      addr_q   <= addr_d;
    end
  end

  assign o_cmp_ready   = ready_q;
  assign o_br_ready    = ready_q;
  assign o_operand1    = op1_q;
  assign o_operand2    = op2_q;
  assign o_cmp_enable  = enable_q;
  assign o_br_done     = done_q;
  assign o_br_taken    = taken_q;
  assign o_br_addr     = addr_q;
  assign o_flags       = flags_q;
  assign o_flags_valid = fvalid_q;
  assign o_flag_err    = err_q;

endmodule
